// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC/BRANCH into ALU operands behind a
// valid/ready output register. Define ALU_ISSUE_SKID_EN to add a 1-entry skid buffer.
module alu_issue #(
  parameter int unsigned RegBits = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [31:0]        instr_i,
  input  logic [RegBits-1:0] pc_i,
  input  logic [RegBits-1:0] rs1_data_i,
  input  logic [RegBits-1:0] rs2_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [RegBits-1:0] a_o,
  output logic [RegBits-1:0] b_o,
  output logic [3:0]         ctrl_o,
  output logic [4:0]         rd_o,
  output logic               we_o,
  output logic               illegal_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        issue_cnt_o
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef enum logic [3:0] {
    CtrlAdd  = 4'd0,
    CtrlSub  = 4'd1,
    CtrlAnd  = 4'd2,
    CtrlOr   = 4'd3,
    CtrlXor  = 4'd4,
    CtrlSlt  = 4'd5,
    CtrlSll  = 4'd6,
    CtrlSltu = 4'd7,
    CtrlSrl  = 4'd8,
    CtrlSra  = 4'd9,
    CtrlSubu = 4'd10
  } ctrl_e;

  typedef struct packed {
    logic [RegBits-1:0] a;
    logic [RegBits-1:0] b;
    logic [3:0]         ctrl;
    logic [4:0]         rd;
    logic               we;
    logic               illegal;
  } beat_t;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [RegBits-1:0] imm_i;
  logic [RegBits-1:0] imm_u;
  logic [RegBits-1:0] shamt;
  logic [31:0]        imm_u32;
  logic [RegBits-1:0] dec_a;
  logic [RegBits-1:0] dec_b;
  ctrl_e              dec_ctrl;
  logic               dec_we;
  logic               dec_legal;
  beat_t              dec;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign imm_u32 = {instr_i[31:12], 12'b0};
  assign imm_i   = RegBits'($signed(instr_i[31:20]));
  assign imm_u   = RegBits'($signed(imm_u32));
  assign shamt   = RegBits'(instr_i[24:20]);

  always_comb begin
    dec_a     = rs1_data_i;
    dec_b     = rs2_data_i;
    dec_ctrl  = CtrlAdd;
    dec_we    = 1'b1;
    dec_legal = 1'b1;
    case (opcode)
      OpcOp: begin
        if (funct7 == 7'h00) begin
          case (funct3)
            3'b000:  dec_ctrl = CtrlAdd;
            3'b001:  dec_ctrl = CtrlSll;
            3'b010:  dec_ctrl = CtrlSlt;
            3'b011:  dec_ctrl = CtrlSltu;
            3'b100:  dec_ctrl = CtrlXor;
            3'b101:  dec_ctrl = CtrlSrl;
            3'b110:  dec_ctrl = CtrlOr;
            default: dec_ctrl = CtrlAnd;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          dec_ctrl = CtrlSub;
        end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
          dec_ctrl = CtrlSra;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OpcOpImm: begin
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_ctrl = CtrlAdd;
          3'b010: dec_ctrl = CtrlSlt;
          3'b011: dec_ctrl = CtrlSltu;
          3'b100: dec_ctrl = CtrlXor;
          3'b110: dec_ctrl = CtrlOr;
          3'b111: dec_ctrl = CtrlAnd;
          3'b001: begin
            dec_b     = shamt;
            dec_ctrl  = CtrlSll;
            dec_legal = (funct7 == 7'h00);
          end
          default: begin
            dec_b = shamt;
            if (funct7 == 7'h00) begin
              dec_ctrl = CtrlSrl;
            end else if (funct7 == 7'h20) begin
              dec_ctrl = CtrlSra;
            end else begin
              dec_legal = 1'b0;
            end
          end
        endcase
      end
      OpcLui: begin
        dec_a = '0;
        dec_b = imm_u;
      end
      OpcAuipc: begin
        dec_a = pc_i;
        dec_b = imm_u;
      end
      OpcBranch: begin
        dec_we = 1'b0;
        case (funct3)
          3'b010, 3'b011: dec_legal = 1'b0;
          3'b110, 3'b111: dec_ctrl  = CtrlSubu;
          default:        dec_ctrl  = CtrlSub;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Illegal beats still issue, but as an inert add of zeros with no writeback.
  always_comb begin
    dec = '0;
    if (dec_legal) begin
      dec.a    = dec_a;
      dec.b    = dec_b;
      dec.ctrl = dec_ctrl;
      dec.rd   = instr_i[11:7];
      dec.we   = dec_we && (instr_i[11:7] != 5'd0);
    end else begin
      dec.illegal = 1'b1;
    end
  end

  beat_t       out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] cnt_q;
  logic        in_fire;
  logic        out_fire;

  assign out_fire = out_valid_q && out_ready_i;
  assign in_fire  = in_valid_i && in_ready_o;

`ifdef ALU_ISSUE_SKID_EN
  beat_t skid_q, skid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  ready_q;

  // Ready comes from a flop (skid empty), so there is no path from out_ready_i.
  assign in_ready_o = ready_q && rst_ni;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) begin
          skid_d = dec;
        end
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end
`else
  assign in_ready_o = rst_ni && (!out_valid_q || out_ready_i);

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (in_fire) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      if (out_fire) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign a_o         = out_q.a;
  assign b_o         = out_q.b;
  assign ctrl_o      = out_q.ctrl;
  assign rd_o        = out_q.rd;
  assign we_o        = out_q.we;
  assign illegal_o   = out_q.illegal;
  assign out_valid_o = out_valid_q;
  assign issue_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, back-to-back issue, stall, reset, counter wrap.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  ctrl;
  logic [4:0]  rd;
  logic        we;
  logic        illegal;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] issue_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  alu_issue #(.RegBits(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .instr_i     (instr),
    .pc_i        (pc),
    .rs1_data_i  (rs1_data),
    .rs2_data_i  (rs2_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_o         (a),
    .b_o         (b),
    .ctrl_o      (ctrl),
    .rd_o        (rd),
    .we_o        (we),
    .illegal_o   (illegal),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .issue_cnt_o (issue_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                             input logic [3:0] ectrl, input logic [4:0] erd, input logic ewe,
                             input logic eill);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".a"}, a, ea);
    check({tag, ".b"}, b, eb);
    check({tag, ".ctrl"}, 32'(ctrl), 32'(ectrl));
    check({tag, ".rd"}, 32'(rd), 32'(erd));
    check({tag, ".we"}, 32'(we), 32'(ewe));
    check({tag, ".illegal"}, 32'(illegal), 32'(eill));
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                      input logic [31:0] r2);
    instr    = i;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni    = 1'b0;
    instr     = '0;
    pc        = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.a", a, 32'd0);
    check("rst.b", b, 32'd0);
    check("rst.ctrl", 32'(ctrl), 32'd0);
    check("rst.rd", 32'(rd), 32'd0);
    check("rst.we", 32'(we), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.cnt", issue_cnt, 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    rst_ni = 1'b1;
    step();
    check("idle.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream with the ALU always ready: one beat issued per cycle.
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);                    // add x3,x1,x2
    expect_beat("add", 32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0);
    send(32'hFFF00093, 32'h0, 32'd0, 32'd9);                    // addi x1,x0,-1
    expect_beat("addi", 32'd0, 32'hFFFFFFFF, 4'd0, 5'd1, 1'b1, 1'b0);
    send(32'h4040D113, 32'h0, 32'hFFFFFFFF, 32'd0);             // srai x2,x1,4
    expect_beat("srai", 32'hFFFFFFFF, 32'd4, 4'd9, 5'd2, 1'b1, 1'b0);
    send(32'h0020E063, 32'h0, 32'd1, 32'd2);                    // bltu x1,x2
    expect_beat("bltu", 32'd1, 32'd2, 4'd10, 5'd0, 1'b0, 1'b0);
    send(32'h0020A063, 32'h0, 32'd1, 32'd2);                    // branch funct3=010
    expect_beat("br010", 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b1);
    send(32'h123452B7, 32'h0, 32'h55, 32'h66);                  // lui x5,0x12345
    expect_beat("lui", 32'd0, 32'h12345000, 4'd0, 5'd5, 1'b1, 1'b0);
    send(32'hABCDE317, 32'h100, 32'h55, 32'h66);                // auipc x6,0xabcde
    expect_beat("auipc", 32'h100, 32'hABCDE000, 4'd0, 5'd6, 1'b1, 1'b0);
    send(32'h40208233, 32'h0, 32'd9, 32'd3);                    // sub x4,x1,x2
    expect_beat("sub", 32'd9, 32'd3, 4'd1, 5'd4, 1'b1, 1'b0);
    send(32'h40209033, 32'h0, 32'h11, 32'h22);                  // funct7=0x20 funct3=001
    expect_beat("op_ill", 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b1);
    send(32'h00208033, 32'h0, 32'd1, 32'd2);                    // add x0,x1,x2
    expect_beat("add_x0", 32'd1, 32'd2, 4'd0, 5'd0, 1'b0, 1'b0);
    send(32'h0000007F, 32'h0, 32'h11, 32'h22);                  // unknown opcode
    expect_beat("opc_ill", 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b1);
    send(32'h0020B3B3, 32'h0, 32'd3, 32'd4);                    // sltu x7,x1,x2
    expect_beat("sltu", 32'd3, 32'd4, 4'd7, 5'd7, 1'b1, 1'b0);
    step();
    check("drain.valid", 32'(out_valid), 32'd0);
    check("drain.cnt", issue_cnt, 32'd12);

    // Reset while a beat sits stalled in the output register.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    check("pre_rst.valid", 32'(out_valid), 32'd1);
    rst_ni = 1'b0;
    step();
    check("mid_rst.valid", 32'(out_valid), 32'd0);
    check("mid_rst.cnt", issue_cnt, 32'd0);
    check("mid_rst.in_ready", 32'(in_ready), 32'd0);
    check("mid_rst.a", a, 32'd0);
    rst_ni = 1'b1;
    step();

    // Three stalled cycles with two beats offered; both must emerge in order.
    check("stall.in_ready0", 32'(in_ready), 32'd1);
    send(32'h002081B3, 32'h0, 32'd1, 32'd2);                    // beat 1: add x3
    instr    = 32'h40208233;                                    // beat 2: sub x4
    rs1_data = 32'd9;
    rs2_data = 32'd3;
    in_valid = 1'b1;
    expect_beat("stall0", 32'd1, 32'd2, 4'd0, 5'd3, 1'b1, 1'b0);
    step();
    expect_beat("stall1", 32'd1, 32'd2, 4'd0, 5'd3, 1'b1, 1'b0);
    step();
    expect_beat("stall2", 32'd1, 32'd2, 4'd0, 5'd3, 1'b1, 1'b0);
    step();
    expect_beat("stall3", 32'd1, 32'd2, 4'd0, 5'd3, 1'b1, 1'b0);
    check("stall.in_ready", 32'(in_ready), 32'd0);
    check("stall.cnt", issue_cnt, 32'd0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    expect_beat("release", 32'd9, 32'd3, 4'd1, 5'd4, 1'b1, 1'b0);
    check("release.cnt", issue_cnt, 32'd1);
    step();
    check("release.valid", 32'(out_valid), 32'd0);
    check("release.cnt2", issue_cnt, 32'd2);

    // Counter wraps from all-ones to zero on the next handshake.
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    send(32'hFFF00093, 32'h0, 32'd0, 32'd0);
    check("wrap.pre", issue_cnt, 32'hFFFFFFFF);
    step();
    check("wrap.cnt", issue_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
